// File: rtl/spi_cmd_ctrl_if.sv
// Bus bundle between the SPI command sequencer and its neighbours: SPI slave word
// port, register bank write/read ports, reply word and sticky status.
interface spi_cmd_ctrl_if #(
   parameter int ADDR_W = 6
);
   // No backpressure anywhere: RX_VALID, FRAME_END, WR_EN and TX_LOAD are single-cycle
   // pulses that must be consumed in the cycle they are high; RD_DATA follows RD_ADDR by one cycle.
   logic              RX_VALID;
   logic [15:0]       RX_WORD;
   logic              FRAME_END;
   logic              WR_EN;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [15:0]       WR_DATA;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [15:0]       RD_DATA;
   logic [15:0]       TX_WORD;
   logic              TX_LOAD;
   logic [7:0]        STATUS;
   logic              STATUS_CLR;
   logic [2:0]        DBG_STATE;

   modport master (
      input  RX_VALID, RX_WORD, FRAME_END, RD_DATA, STATUS_CLR,
      output WR_EN, WR_ADDR, WR_DATA, RD_ADDR, TX_WORD, TX_LOAD, STATUS, DBG_STATE
   );

   modport slave (
      output RX_VALID, RX_WORD, FRAME_END, RD_DATA, STATUS_CLR,
      input  WR_EN, WR_ADDR, WR_DATA, RD_ADDR, TX_WORD, TX_LOAD, STATUS, DBG_STATE
   );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: decodes SPI words into single writes, bursts and reads,
// drives the register bank and loads the reply word for the next frame.
module spi_cmd_ctrl #(
   parameter int          ADDR_W    = 6,
   parameter logic [15:0] IDLE_WORD = 16'hA500
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RST_N,
   spi_cmd_ctrl_if.master    bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WDATA   = 3'd1,
      S_BURST   = 3'd2,
      S_RD_WAIT = 3'd3,
      S_RD_LOAD = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]       tx_word_q, tx_word_d;
   logic              tx_load_q, tx_load_d;
   logic [2:0]        status_q, status_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        burst_cnt_q, burst_cnt_d;
   logic              rd_loaded_q, rd_loaded_d;

   logic [1:0]        rx_op;
   logic [ADDR_W-1:0] rx_addr;
   logic [7:0]        rx_cnt;
   logic              set_ovf, set_bad, set_abort;

   assign rx_op   = bus.RX_WORD[15:14];
   assign rx_addr = bus.RX_WORD[8 +: ADDR_W];
   assign rx_cnt  = bus.RX_WORD[7:0];

   always_comb begin
      state_d     = state_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_addr_d   = rd_addr_q;
      tx_word_d   = tx_word_q;
      tx_load_d   = 1'b0;
      addr_d      = addr_q;
      burst_cnt_d = burst_cnt_q;
      rd_loaded_d = rd_loaded_q;
      set_ovf     = 1'b0;
      set_bad     = 1'b0;
      set_abort   = 1'b0;

      // Word processing first; FRAME_END is applied afterwards to the resulting state.
      unique case (state_q)
         S_IDLE: begin
            if (bus.RX_VALID) begin
               unique case (rx_op)
                  2'b00: ;
                  2'b01: begin
                     addr_d  = rx_addr;
                     state_d = S_WDATA;
                  end
                  2'b10: begin
                     rd_addr_d = rx_addr;
                     state_d   = S_RD_WAIT;
                  end
                  default: begin
                     if (&rx_cnt && &rx_addr) begin
                        set_bad = 1'b1;
                     end else begin
                        addr_d      = rx_addr;
                        burst_cnt_d = rx_cnt;
                        state_d     = S_BURST;
                     end
                  end
               endcase
            end
         end
         S_WDATA: begin
            if (bus.RX_VALID) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.RX_WORD;
               state_d   = S_IDLE;
            end
         end
         S_BURST: begin
            if (bus.RX_VALID) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.RX_WORD;
               addr_d    = addr_q + 1'b1;
               // Any increment past the top address counts, including after the last word.
               set_ovf   = &addr_q;
               if (burst_cnt_q == 8'd0) begin
                  state_d = S_IDLE;
               end else begin
                  burst_cnt_d = burst_cnt_q - 8'd1;
               end
            end
         end
         S_RD_WAIT: begin
            set_bad = bus.RX_VALID;
            state_d = S_RD_LOAD;
         end
         S_RD_LOAD: begin
            set_bad     = bus.RX_VALID;
            tx_word_d   = bus.RD_DATA;
            tx_load_d   = 1'b1;
            rd_loaded_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A frame ending during a read lets the read finish and keeps its reply for the next frame.
      if (bus.FRAME_END && state_q != S_RD_WAIT && state_q != S_RD_LOAD) begin
         unique case (state_d)
            S_IDLE: begin
               if (!rd_loaded_q) begin
                  tx_word_d = IDLE_WORD | {8'h00, 5'b00000, status_q};
                  tx_load_d = 1'b1;
               end
               rd_loaded_d = 1'b0;
            end
            S_WDATA, S_BURST: begin
               set_abort   = 1'b1;
               burst_cnt_d = 8'd0;
               state_d     = S_IDLE;
            end
            default: ;
         endcase
      end

      status_d = (bus.STATUS_CLR ? 3'b000 : status_q) | {set_ovf, set_bad, set_abort};
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state_q     <= S_IDLE;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         tx_word_q   <= IDLE_WORD;
         tx_load_q   <= 1'b0;
         status_q    <= 3'b000;
         addr_q      <= '0;
         burst_cnt_q <= 8'd0;
         rd_loaded_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_addr_q   <= rd_addr_d;
         tx_word_q   <= tx_word_d;
         tx_load_q   <= tx_load_d;
         status_q    <= status_d;
         addr_q      <= addr_d;
         burst_cnt_q <= burst_cnt_d;
         rd_loaded_q <= rd_loaded_d;
      end
   end

   assign bus.WR_EN     = wr_en_q;
   assign bus.WR_ADDR   = wr_addr_q;
   assign bus.WR_DATA   = wr_data_q;
   assign bus.RD_ADDR   = rd_addr_q;
   assign bus.TX_WORD   = tx_word_q;
   assign bus.TX_LOAD   = tx_load_q;
   assign bus.STATUS    = {5'b00000, status_q};
   assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: vector table, directed multi-cycle sequences and a
// randomized write/burst/read stream checked against a transaction-level model.
module tb_spi_cmd_ctrl;
   localparam int AW = 6;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic rst_n;

   spi_cmd_ctrl_if #(.ADDR_W(AW)) bus ();

   spi_cmd_ctrl #(.ADDR_W(AW), .IDLE_WORD(16'hA500)) dut (
      .SYS_CLK   (clk),
      .SYS_RST_N (rst_n),
      .bus       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register bank: registered read, written by the DUT or by bench preload.
   logic [15:0]   bank [DEPTH];
   logic          bk_we;
   logic [AW-1:0] bk_addr;
   logic [15:0]   bk_data;

   always @(posedge clk) begin
      if (bk_we) bank[bk_addr] <= bk_data;
      else if (bus.WR_EN) bank[bus.WR_ADDR] <= bus.WR_DATA;
      bus.RD_DATA <= bank[bus.RD_ADDR];
   end

   // Observed bank writes {addr, data}.
   logic [AW+15:0] obs_q [$];
   logic [AW+15:0] exp_q [$];

   always @(negedge clk) begin
      if (rst_n && bus.WR_EN) obs_q.push_back({bus.WR_ADDR, bus.WR_DATA});
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [15:0] w, input logic fe, input logic clr);
      @(negedge clk);
      bus.RX_VALID   = 1'b1;
      bus.RX_WORD    = w;
      bus.FRAME_END  = fe;
      bus.STATUS_CLR = clr;
      @(negedge clk);
      bus.RX_VALID   = 1'b0;
      bus.FRAME_END  = 1'b0;
      bus.STATUS_CLR = 1'b0;
   endtask

   task automatic pulse_fe();
      @(negedge clk);
      bus.FRAME_END = 1'b1;
      @(negedge clk);
      bus.FRAME_END = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      bus.STATUS_CLR = 1'b1;
      @(negedge clk);
      bus.STATUS_CLR = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
      @(negedge clk);
      bk_we = 1'b1; bk_addr = a; bk_data = d;
      @(negedge clk);
      bk_we = 1'b0;
   endtask

   // Called right after send_word of a read command; counts cycles to TX_LOAD.
   task automatic wait_tx(input string name, input logic [15:0] exp_word);
      int n = 0;
      while (!bus.TX_LOAD && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_lat"}, n, 2);
      chk({name, "_word"}, bus.TX_WORD, exp_word);
   endtask

   typedef struct {
      bit          is_read;
      logic [15:0] cmd;
      logic [15:0] data;
      logic [AW-1:0] exp_addr;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs [7];

   // Transaction-level reference state for the random phase.
   logic [15:0] mem_model [DEPTH];
   bit          mem_valid [DEPTH];
   bit          exp_ovf;

   initial begin
      vecs[0] = '{1'b0, 16'h4500, 16'h1234, 6'd5,  16'h1234};
      vecs[1] = '{1'b0, 16'h7F00, 16'hFFFF, 6'd63, 16'hFFFF};
      vecs[2] = '{1'b0, 16'h4000, 16'h0001, 6'd0,  16'h0001};
      vecs[3] = '{1'b0, 16'h40AB, 16'h5A5A, 6'd0,  16'h5A5A};
      vecs[4] = '{1'b1, 16'h8900, 16'hBEEF, 6'd9,  16'hBEEF};
      vecs[5] = '{1'b1, 16'hBF00, 16'h1357, 6'd63, 16'h1357};
      vecs[6] = '{1'b1, 16'h80FF, 16'h2468, 6'd0,  16'h2468};

      rst_n = 1'b0;
      bus.RX_VALID = 1'b0; bus.RX_WORD = '0; bus.FRAME_END = 1'b0; bus.STATUS_CLR = 1'b0;
      bk_we = 1'b0; bk_addr = '0; bk_data = '0;
      repeat (3) @(negedge clk);

      chk("rst_wr_en",   bus.WR_EN,   0);
      chk("rst_wr_addr", bus.WR_ADDR, 0);
      chk("rst_wr_data", bus.WR_DATA, 0);
      chk("rst_rd_addr", bus.RD_ADDR, 0);
      chk("rst_tx_load", bus.TX_LOAD, 0);
      chk("rst_tx_word", bus.TX_WORD, 16'hA500);
      chk("rst_status",  bus.STATUS,  0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven single writes and reads.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_read) begin
            preload(vecs[i].exp_addr, vecs[i].data);
            send_word(vecs[i].cmd, 1'b0, 1'b0);
            chk($sformatf("vec%0d_rd_addr", i), bus.RD_ADDR, vecs[i].exp_addr);
            wait_tx($sformatf("vec%0d", i), vecs[i].exp_word);
         end else begin
            send_word(vecs[i].cmd, 1'b0, 1'b0);
            chk($sformatf("vec%0d_early", i), bus.WR_EN, 0);
            send_word(vecs[i].data, 1'b0, 1'b0);
            chk($sformatf("vec%0d_wr_en", i), bus.WR_EN, 1);
            chk($sformatf("vec%0d_wr_addr", i), bus.WR_ADDR, vecs[i].exp_addr);
            chk($sformatf("vec%0d_wr_data", i), bus.WR_DATA, vecs[i].exp_word);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), bus.WR_EN, 0);
         end
      end

      // Frame end after a loaded read keeps the read reply.
      pulse_fe();
      chk("fe_after_rd_load", bus.TX_LOAD, 0);
      chk("fe_after_rd_word", bus.TX_WORD, 16'h2468);
      pulse_fe();
      chk("fe_idle_load", bus.TX_LOAD, 1);
      chk("fe_idle_word", bus.TX_WORD, 16'hA500);

      // Burst across the top of the bank.
      send_word(16'hFE02, 1'b0, 1'b0);
      send_word(16'h1111, 1'b0, 1'b0);
      chk("burst_w0_addr", {bus.WR_EN, bus.WR_ADDR}, {1'b1, 6'd62});
      send_word(16'h2222, 1'b0, 1'b0);
      chk("burst_w1_addr", {bus.WR_EN, bus.WR_ADDR}, {1'b1, 6'd63});
      send_word(16'h3333, 1'b0, 1'b0);
      chk("burst_w2_addr", {bus.WR_EN, bus.WR_ADDR}, {1'b1, 6'd0});
      chk("burst_w2_data", bus.WR_DATA, 16'h3333);
      chk("burst_status", bus.STATUS, 8'h04);
      send_word(16'h0000, 1'b0, 1'b0);
      chk("burst_done_idle", bus.WR_EN, 0);
      pulse_clr();
      chk("clr_status", bus.STATUS, 8'h00);

      // Burst aborted by frame end.
      obs_q.delete();
      send_word(16'hCA04, 1'b0, 1'b0);
      send_word(16'hAAAA, 1'b0, 1'b0);
      send_word(16'hBBBB, 1'b0, 1'b0);
      pulse_fe();
      chk("abort_status", bus.STATUS, 8'h01);
      send_word(16'h1111, 1'b0, 1'b0);
      chk("abort_no_write", bus.WR_EN, 0);
      chk("abort_nwrites", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("abort_wr0", obs_q[0], {6'd10, 16'hAAAA});
         chk("abort_wr1", obs_q[1], {6'd11, 16'hBBBB});
      end

      // Idle frame end reports status; then clear.
      pulse_fe();
      chk("idle_fe_load", bus.TX_LOAD, 1);
      chk("idle_fe_word", bus.TX_WORD, 16'hA501);
      pulse_clr();
      chk("clr_after_abort", bus.STATUS, 8'h00);

      // Reserved burst with a same-cycle clear: the set wins.
      send_word(16'hFFFF, 1'b0, 1'b1);
      chk("reserved_status", bus.STATUS, 8'h02);
      send_word(16'h1234, 1'b0, 1'b0);
      chk("reserved_idle", bus.WR_EN, 0);
      pulse_clr();

      // Word arriving during a read is dropped; the read still completes.
      send_word(16'h8900, 1'b0, 1'b0);
      send_word(16'h4500, 1'b0, 1'b0);
      chk("rd_drop_load", bus.TX_LOAD, 1);
      chk("rd_drop_word", bus.TX_WORD, 16'hBEEF);
      chk("rd_drop_status", bus.STATUS, 8'h02);
      send_word(16'h1234, 1'b0, 1'b0);
      chk("rd_drop_no_write", bus.WR_EN, 0);
      pulse_fe();
      pulse_clr();

      // Data word and frame end together: write completes, no abort.
      send_word(16'h4500, 1'b0, 1'b0);
      send_word(16'h5678, 1'b1, 1'b0);
      chk("wd_fe_write", {bus.WR_EN, bus.WR_ADDR, bus.WR_DATA}, {1'b1, 6'd5, 16'h5678});
      chk("wd_fe_no_abort", bus.STATUS, 8'h00);

      // Reset in the middle of a burst.
      send_word(16'hCA07, 1'b0, 1'b0);
      send_word(16'h0101, 1'b0, 1'b0);
      send_word(16'h0202, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wr_en", bus.WR_EN, 0);
      chk("rst_mid_tx", bus.TX_WORD, 16'hA500);
      @(negedge clk);
      rst_n = 1'b1;
      send_word(16'h4500, 1'b0, 1'b0);
      send_word(16'h1234, 1'b0, 1'b0);
      chk("post_rst_write", {bus.WR_EN, bus.WR_ADDR, bus.WR_DATA}, {1'b1, 6'd5, 16'h1234});

      // Random stream against the transaction model.
      repeat (2) @(negedge clk);
      obs_q.delete();
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int a = 0; a < DEPTH; a++) mem_valid[a] = 1'b0;

      for (int t = 0; t < 60; t++) begin
         int kind;
         logic [AW-1:0] a;
         logic [15:0] d;
         kind = $urandom_range(0, 2);
         a = AW'($urandom_range(0, DEPTH - 1));
         if (kind == 2) begin
            int tries = 0;
            while (!mem_valid[a] && tries < 200) begin
               a = AW'($urandom_range(0, DEPTH - 1));
               tries++;
            end
            if (!mem_valid[a]) kind = 0;
         end
         if (kind == 0) begin
            d = 16'($urandom);
            send_word({2'b01, a, 8'($urandom)}, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(d, 1'b0, 1'b0);
            exp_q.push_back({a, d});
            mem_model[a] = d;
            mem_valid[a] = 1'b1;
         end else if (kind == 1) begin
            int cnt;
            cnt = $urandom_range(0, 7);
            send_word({2'b11, a, 8'(cnt)}, 1'b0, 1'b0);
            for (int k = 0; k <= cnt; k++) begin
               logic [AW-1:0] wa;
               wa = AW'((int'(a) + k) % DEPTH);
               d = 16'($urandom);
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send_word(d, 1'b0, 1'b0);
               exp_q.push_back({wa, d});
               mem_model[wa] = d;
               mem_valid[wa] = 1'b1;
            end
            if (int'(a) + cnt + 1 >= DEPTH) exp_ovf = 1'b1;
         end else begin
            send_word({2'b10, a, 8'($urandom)}, 1'b0, 1'b0);
            wait_tx($sformatf("rand%0d_rd", t), mem_model[a]);
         end
         repeat (2) @(negedge clk);
         while (exp_q.size() > 0) begin
            logic [AW+15:0] e;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
               chk($sformatf("rand%0d_missing_wr", t), 0, e);
            end else begin
               chk($sformatf("rand%0d_wr", t), obs_q.pop_front(), e);
            end
         end
         chk($sformatf("rand%0d_extra_wr", t), obs_q.size(), 0);
         obs_q.delete();
      end
      chk("rand_status", bus.STATUS, {5'b0, exp_ovf, 2'b00});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
